// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_arbiter
// Brief   : Round-robin req/gnt arbiter sharing one single-port memory between
//           requester ports A and B, with registered memory commands.
// Revision: 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);

  state_t              r_state, w_state_nxt;
  logic                r_ptr, w_ptr_nxt;       // 0: A has priority, 1: B
  logic                r_owner, w_owner_nxt;   // port of the outstanding command, 1 = B
  logic                r_rd, w_rd_nxt;
  logic                r_bad, w_bad_nxt;
  logic                r_a_gnt, w_a_gnt_nxt;
  logic                r_b_gnt, w_b_gnt_nxt;
  logic                r_err, w_err_nxt;
  logic                r_mem_re, w_mem_re_nxt;
  logic                r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic                r_a_rvalid, w_a_rvalid_nxt;
  logic                r_b_rvalid, w_b_rvalid_nxt;
  logic [DATA_W-1:0]   r_a_rdata, w_a_rdata_nxt;
  logic [DATA_W-1:0]   r_b_rdata, w_b_rdata_nxt;

  logic                w_pick_b;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_legal;

  // B wins when it is the only requester, or when both ask and B holds priority
  assign w_pick_b    = b_req & (~a_req | r_ptr);
  assign w_sel_we    = w_pick_b ? b_we    : a_we;
  assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
  assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;
  assign w_legal     = ({1'b0, w_sel_addr} < c_depth);

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_owner_nxt     = r_owner;
    w_rd_nxt        = r_rd;
    w_bad_nxt       = r_bad;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_a_rdata_nxt   = r_a_rdata;
    w_b_rdata_nxt   = r_b_rdata;
    w_a_gnt_nxt     = 1'b0;
    w_b_gnt_nxt     = 1'b0;
    w_err_nxt       = 1'b0;
    w_mem_re_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_a_rvalid_nxt  = 1'b0;
    w_b_rvalid_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (a_req | b_req) begin
          w_a_gnt_nxt     = ~w_pick_b;
          w_b_gnt_nxt     = w_pick_b;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_mem_we_nxt    = w_sel_we & w_legal;
          w_mem_re_nxt    = ~w_sel_we & w_legal;
          w_err_nxt       = ~w_legal;
          w_owner_nxt     = w_pick_b;
          w_rd_nxt        = ~w_sel_we;
          w_bad_nxt       = ~w_legal;
          w_ptr_nxt       = ~w_pick_b;
          w_state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_nxt = r_rd ? S_RDWAIT : S_IDLE;
      end
      S_RDWAIT: begin
        // illegal reads still complete, but return zero instead of memory data
        if (r_owner) begin
          w_b_rdata_nxt  = r_bad ? '0 : mem_rdata;
          w_b_rvalid_nxt = 1'b1;
        end else begin
          w_a_rdata_nxt  = r_bad ? '0 : mem_rdata;
          w_a_rvalid_nxt = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ptr       <= 1'b0;
      r_owner     <= 1'b0;
      r_rd        <= 1'b0;
      r_bad       <= 1'b0;
      r_a_gnt     <= 1'b0;
      r_b_gnt     <= 1'b0;
      r_err       <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_a_rvalid  <= 1'b0;
      r_b_rvalid  <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_owner     <= w_owner_nxt;
      r_rd        <= w_rd_nxt;
      r_bad       <= w_bad_nxt;
      r_a_gnt     <= w_a_gnt_nxt;
      r_b_gnt     <= w_b_gnt_nxt;
      r_err       <= w_err_nxt;
      r_mem_re    <= w_mem_re_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_a_rvalid  <= w_a_rvalid_nxt;
      r_b_rvalid  <= w_b_rvalid_nxt;
      r_a_rdata   <= w_a_rdata_nxt;
      r_b_rdata   <= w_b_rdata_nxt;
    end
  end

  assign a_gnt     = r_a_gnt;
  assign b_gnt     = r_b_gnt;
  assign a_rvalid  = r_a_rvalid;
  assign b_rvalid  = r_b_rvalid;
  assign a_rdata   = r_a_rdata;
  assign b_rdata   = r_b_rdata;
  assign err       = r_err;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_re    = r_mem_re;
  assign mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_arbiter
// Brief   : Vector table, hand sequences and random traffic for mem_arbiter
//           (DEPTH 32 and DEPTH 24 instances, each with its own memory).
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic sel24 = 1'b0;
  logic mem_init = 1'b0;
  always #5 clk = ~clk;

  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [4:0]  a_addr = '0, b_addr = '0;
  logic [15:0] a_wdata = '0, b_wdata = '0;

  logic a_req_1, b_req_1, a_req_2, b_req_2;
  assign a_req_1 = a_req & ~sel24;
  assign b_req_1 = b_req & ~sel24;
  assign a_req_2 = a_req & sel24;
  assign b_req_2 = b_req & sel24;

  logic        a_gnt_1, a_rvalid_1, b_gnt_1, b_rvalid_1, err_1, mem_re_1, mem_we_1;
  logic [15:0] a_rdata_1, b_rdata_1, mem_wdata_1, mem_rdata_1;
  logic [4:0]  mem_addr_1;
  logic        a_gnt_2, a_rvalid_2, b_gnt_2, b_rvalid_2, err_2, mem_re_2, mem_we_2;
  logic [15:0] a_rdata_2, b_rdata_2, mem_wdata_2, mem_rdata_2;
  logic [4:0]  mem_addr_2;

  mem_arbiter #(.ADDR_W(5), .DATA_W(16), .DEPTH(32)) dut (
    .clk(clk), .reset(rst),
    .a_req(a_req_1), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_1), .a_rvalid(a_rvalid_1), .a_rdata(a_rdata_1),
    .b_req(b_req_1), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_1), .b_rvalid(b_rvalid_1), .b_rdata(b_rdata_1),
    .err(err_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_re(mem_re_1), .mem_we(mem_we_1), .mem_rdata(mem_rdata_1)
  );

  mem_arbiter #(.ADDR_W(5), .DATA_W(16), .DEPTH(24)) dut24 (
    .clk(clk), .reset(rst),
    .a_req(a_req_2), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt_2), .a_rvalid(a_rvalid_2), .a_rdata(a_rdata_2),
    .b_req(b_req_2), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt_2), .b_rvalid(b_rvalid_2), .b_rdata(b_rdata_2),
    .err(err_2), .mem_addr(mem_addr_2), .mem_wdata(mem_wdata_2),
    .mem_re(mem_re_2), .mem_we(mem_we_2), .mem_rdata(mem_rdata_2)
  );

  function automatic logic [15:0] f(input int i);
    if (i == 3) return 16'h1234;
    return 16'hA000 + 16'(i * 17);
  endfunction

  // Memories behind each instance: read data appears the cycle after mem_re
  logic [15:0] mem1 [32];
  logic [15:0] mem2 [32];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= f(i);
        mem2[i] <= f(i);
      end
    end else begin
      if (mem_we_1) mem1[mem_addr_1] <= mem_wdata_1;
      if (mem_re_1) mem_rdata_1 <= mem1[mem_addr_1];
      if (mem_we_2) mem2[mem_addr_2] <= mem_wdata_2;
      if (mem_re_2) mem_rdata_2 <= mem2[mem_addr_2];
    end
  end

  logic o_a_gnt, o_b_gnt, o_a_rvalid, o_b_rvalid, o_err, o_mem_re, o_mem_we;
  logic [15:0] o_a_rdata, o_b_rdata, o_mem_wdata;
  logic [4:0]  o_mem_addr;
  assign o_a_gnt     = sel24 ? a_gnt_2     : a_gnt_1;
  assign o_b_gnt     = sel24 ? b_gnt_2     : b_gnt_1;
  assign o_a_rvalid  = sel24 ? a_rvalid_2  : a_rvalid_1;
  assign o_b_rvalid  = sel24 ? b_rvalid_2  : b_rvalid_1;
  assign o_a_rdata   = sel24 ? a_rdata_2   : a_rdata_1;
  assign o_b_rdata   = sel24 ? b_rdata_2   : b_rdata_1;
  assign o_err       = sel24 ? err_2       : err_1;
  assign o_mem_re    = sel24 ? mem_re_2    : mem_re_1;
  assign o_mem_we    = sel24 ? mem_we_2    : mem_we_1;
  assign o_mem_addr  = sel24 ? mem_addr_2  : mem_addr_1;
  assign o_mem_wdata = sel24 ? mem_wdata_2 : mem_wdata_1;

  logic [59:0] outs1, outs2;
  assign outs1 = {a_gnt_1, a_rvalid_1, a_rdata_1, b_gnt_1, b_rvalid_1, b_rdata_1,
                  err_1, mem_addr_1, mem_wdata_1, mem_re_1, mem_we_1};
  assign outs2 = {a_gnt_2, a_rvalid_2, a_rdata_2, b_gnt_2, b_rvalid_2, b_rdata_2,
                  err_2, mem_addr_2, mem_wdata_2, mem_re_2, mem_we_2};

  typedef struct packed {
    logic        s24, ra, rb, awe;
    logic [4:0]  aaddr;
    logic [15:0] awd;
    logic        bwe;
    logic [4:0]  baddr;
    logic [15:0] bwd;
    logic        first_b, a_err, b_err;
    logic [15:0] a_rd, b_rd;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  // Transaction-level reference: memory contents and the next priority port
  logic [15:0] mdl_mem [2][32];
  logic        mdl_ptr [2];

  function automatic void serve(input int s, input logic we, input logic [4:0] ad,
                                input logic [15:0] wd, output logic e, output logic [15:0] rd);
    e  = (int'(ad) >= ((s != 0) ? 24 : 32));
    rd = 16'h0;
    if (!e && !we) rd = mdl_mem[s][ad];
    if (!e && we)  mdl_mem[s][ad] = wd;
  endfunction

  function automatic void predict(inout vec_t v);
    int   s;
    logic order [2];
    int   cnt;
    s = v.s24 ? 1 : 0;
    if (v.ra && v.rb) begin
      order[0] = mdl_ptr[s];
      order[1] = !mdl_ptr[s];
      cnt = 2;
    end else begin
      order[0] = v.rb;
      order[1] = 1'b0;
      cnt = 1;
    end
    v.first_b = order[0];
    for (int k = 0; k < cnt; k++) begin
      if (order[k]) serve(s, v.bwe, v.baddr, v.bwd, v.b_err, v.b_rd);
      else          serve(s, v.awe, v.aaddr, v.awd, v.a_err, v.a_rd);
      mdl_ptr[s] = !order[k];
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_req = 1'b0; b_req = 1'b0;
    @(negedge clk);
    check("reset_outputs_d32", {4'h0, outs1}, 64'h0);
    check("reset_outputs_d24", {4'h0, outs2}, 64'h0);
    rst = 1'b0;
    mdl_ptr[0] = 1'b0;
    mdl_ptr[1] = 1'b0;
  endtask

  task automatic check_gnt(input string p, input int n, input int exp_n, input logic we,
                           input logic [4:0] ad, input logic [15:0] wd, input logic e);
    check({p, "_gnt_cycle"}, n, exp_n);
    check({p, "_err"}, o_err, e);
    check({p, "_mem_re"}, o_mem_re, !we && !e);
    check({p, "_mem_we"}, o_mem_we, we && !e);
    if (!e) check({p, "_mem_addr"}, o_mem_addr, ad);
    if (!e && we) check({p, "_mem_wdata"}, o_mem_wdata, wd);
  endtask

  // Present one or two requests together and follow them to completion
  task automatic run_pair(input vec_t v);
    int   n, exp_an, exp_bn, a_gn, b_gn;
    logic a_pg, b_pg, a_pr, b_pr;
    exp_an = -1; exp_bn = -1; a_gn = -1; b_gn = -1;
    if (v.ra && v.rb) begin
      if (v.first_b) begin exp_bn = 1; exp_an = v.bwe ? 3 : 4; end
      else           begin exp_an = 1; exp_bn = v.awe ? 3 : 4; end
    end else begin
      if (v.ra) exp_an = 1;
      if (v.rb) exp_bn = 1;
    end
    @(negedge clk);
    sel24 = v.s24;
    a_req = v.ra; a_we = v.awe; a_addr = v.aaddr; a_wdata = v.awd;
    b_req = v.rb; b_we = v.bwe; b_addr = v.baddr; b_wdata = v.bwd;
    a_pg = v.ra; b_pg = v.rb; a_pr = 1'b0; b_pr = 1'b0;
    n = 0;
    while ((a_pg || b_pg || a_pr || b_pr) && n < 30) begin
      @(posedge clk); n++; @(negedge clk);
      check("no_double_gnt", o_a_gnt & o_b_gnt, 0);
      check("re_we_exclusive", o_mem_re & o_mem_we, 0);
      if (!o_a_gnt && !o_b_gnt)
        check("cmd_without_gnt", {o_err, o_mem_re, o_mem_we}, 0);
      if (o_a_gnt) begin
        check_gnt("a", n, a_pg ? exp_an : -1, v.awe, v.aaddr, v.awd, v.a_err);
        a_req = 1'b0; a_pg = 1'b0;
        if (!v.awe) begin a_pr = 1'b1; a_gn = n; end
      end
      if (o_b_gnt) begin
        check_gnt("b", n, b_pg ? exp_bn : -1, v.bwe, v.baddr, v.bwd, v.b_err);
        b_req = 1'b0; b_pg = 1'b0;
        if (!v.bwe) begin b_pr = 1'b1; b_gn = n; end
      end
      if (o_a_rvalid) begin
        check("a_rvalid_cycle", n, a_pr ? a_gn + 2 : -1);
        check("a_rdata", o_a_rdata, v.a_rd);
        a_pr = 1'b0;
      end
      if (o_b_rvalid) begin
        check("b_rvalid_cycle", n, b_pr ? b_gn + 2 : -1);
        check("b_rdata", o_b_rdata, v.b_rd);
        b_pr = 1'b0;
      end
    end
    check("txn_completed", {a_pg, b_pg, a_pr, b_pr}, 0);
    a_req = 1'b0; b_req = 1'b0;
  endtask

  vec_t tbl [12];
  vec_t v;
  int   k;
  int   mode;

  initial begin
    tbl[0]  = '{1'b0,1'b1,1'b0, 1'b0,5'd3,16'h0,     1'b0,5'd0,16'h0,      1'b0,1'b0,1'b0, 16'h1234,16'h0};
    tbl[1]  = '{1'b0,1'b0,1'b1, 1'b0,5'd0,16'h0,     1'b1,5'd31,16'hBEEF,  1'b1,1'b0,1'b0, 16'h0,16'h0};
    tbl[2]  = '{1'b0,1'b1,1'b0, 1'b0,5'd31,16'h0,    1'b0,5'd0,16'h0,      1'b0,1'b0,1'b0, 16'hBEEF,16'h0};
    tbl[3]  = '{1'b0,1'b1,1'b1, 1'b0,5'd7,16'h0,     1'b0,5'd8,16'h0,      1'b1,1'b0,1'b0, 16'hA077,16'hA088};
    tbl[4]  = '{1'b0,1'b1,1'b1, 1'b1,5'd5,16'h5555,  1'b0,5'd5,16'h0,      1'b1,1'b0,1'b0, 16'h0,16'hA055};
    tbl[5]  = '{1'b0,1'b0,1'b1, 1'b0,5'd0,16'h0,     1'b0,5'd0,16'h0,      1'b1,1'b0,1'b0, 16'h0,16'hA000};
    tbl[6]  = '{1'b0,1'b1,1'b0, 1'b0,5'd5,16'h0,     1'b0,5'd0,16'h0,      1'b0,1'b0,1'b0, 16'h5555,16'h0};
    tbl[7]  = '{1'b1,1'b1,1'b0, 1'b0,5'd25,16'h0,    1'b0,5'd0,16'h0,      1'b0,1'b1,1'b0, 16'h0,16'h0};
    tbl[8]  = '{1'b1,1'b1,1'b0, 1'b1,5'd30,16'h7777, 1'b0,5'd0,16'h0,      1'b0,1'b1,1'b0, 16'h0,16'h0};
    tbl[9]  = '{1'b1,1'b0,1'b1, 1'b0,5'd0,16'h0,     1'b0,5'd23,16'h0,     1'b1,1'b0,1'b0, 16'h0,16'hA187};
    tbl[10] = '{1'b1,1'b1,1'b1, 1'b0,5'd24,16'h0,    1'b1,5'd0,16'hDEAD,   1'b0,1'b1,1'b0, 16'h0,16'h0};
    tbl[11] = '{1'b1,1'b0,1'b1, 1'b0,5'd0,16'h0,     1'b0,5'd0,16'h0,      1'b1,1'b0,1'b0, 16'h0,16'hDEAD};

    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 32; i++) mdl_mem[s][i] = f(i);
    rst = 1'b1;
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      v = tbl[i];
      predict(v);
      run_pair(tbl[i]);
    end

    // Both ports reading continuously: grants alternate A,B,... three cycles apart
    do_reset();
    sel24 = 1'b0;
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd2;
    k = 0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); @(negedge clk);
      check("rr_no_double_gnt", a_gnt_1 & b_gnt_1, 0);
      if (a_gnt_1 | b_gnt_1) begin
        check("rr_gnt_cycle", n, 1 + 3 * k);
        check("rr_gnt_port_is_b", b_gnt_1, k % 2);
        k++;
        if (k == 5) begin a_req = 1'b0; b_req = 1'b0; end
      end
      if (a_rvalid_1) check("rr_a_rdata", a_rdata_1, f(1));
      if (b_rvalid_1) check("rr_b_rdata", b_rdata_1, f(2));
    end
    check("rr_gnt_count", k, 5);

    // Reset pulse during RDWAIT drops the read entirely
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd4;
    @(posedge clk); @(negedge clk);
    check("rstmid_a_gnt", a_gnt_1, 1);
    a_req = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_outputs_zero", {4'h0, outs1}, 64'h0);
    #1;
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); @(negedge clk);
      check("rstmid_no_rvalid", a_rvalid_1, 0);
    end
    v = '{1'b0,1'b1,1'b1, 1'b0,5'd10,16'h0, 1'b0,5'd11,16'h0, 1'b0,1'b0,1'b0, f(10), f(11)};
    run_pair(v);

    // B req pulsed only during A's ISSUE cycle is never granted
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd6;
    @(posedge clk); @(negedge clk);
    check("pulse_a_gnt", a_gnt_1, 1);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd9;
    @(posedge clk); @(negedge clk);
    b_req = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk); @(negedge clk);
      check("pulse_no_b_gnt", b_gnt_1, 0);
    end

    // B req raised in ISSUE and held is granted in the next IDLE
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 5'd6;
    @(posedge clk); @(negedge clk);
    check("held_a_gnt", a_gnt_1, 1);
    a_req = 1'b0;
    b_req = 1'b1; b_we = 1'b0; b_addr = 5'd9;
    for (int n = 2; n <= 6; n++) begin
      @(posedge clk); @(negedge clk);
      check("held_b_gnt", b_gnt_1, n == 4);
      if (n == 4) b_req = 1'b0;
      if (n == 3) check("held_a_rdata", {a_rvalid_1, a_rdata_1}, {1'b1, f(6)});
      if (n == 6) check("held_b_rdata", {b_rvalid_1, b_rdata_1}, {1'b1, f(9)});
    end

    // Random traffic against the transaction-level model
    do_reset();
    for (int it = 0; it < 60; it++) begin
      v = '0;
      v.s24   = 1'($urandom_range(0, 1));
      mode    = int'($urandom_range(1, 3));
      v.ra    = mode[0];
      v.rb    = mode[1];
      v.awe   = 1'($urandom_range(0, 1));
      v.aaddr = 5'($urandom);
      v.awd   = 16'($urandom);
      v.bwe   = 1'($urandom_range(0, 1));
      v.baddr = 5'($urandom);
      v.bwd   = 16'($urandom);
      predict(v);
      run_pair(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
